// File: rtl/order_entry.sv
// order_entry: turns five raw push buttons into a packed move order for the
// 7-segment order display. The buttons are synchronized, debounced and
// edge-detected, then a small FSM appends 2-bit direction codes and handles
// commit and clear.
module order_entry #(
    parameter int unsigned DIV_W      = 12,
    parameter int unsigned DB_SAMPLES = 3,
    parameter int unsigned MAX_MOVES  = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             btn,
    output logic [2*MAX_MOVES-1:0] ord,
    output logic [2*MAX_MOVES-1:0] cnt,
    output logic                   comp,
    output logic                   move_vld,
    output logic [1:0]             move_code,
    output logic                   ovf
);

    localparam int unsigned OrdW = 2 * MAX_MOVES;
    localparam int unsigned CntW = $clog2(MAX_MOVES + 1);

    typedef enum logic [1:0] {StEntry, StFull, StDone} state_e;

    logic [4:0]       sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [4:0]       lvl_q, lvl_d, lvl_dly_q;
    logic [4:0][3:0]  dbc_q, dbc_d;
    logic [4:0]       evt;

    logic             is_enter, dir_vld;
    logic [1:0]       dir_code;

    state_e           state_q, state_d;
    logic [OrdW-1:0]  ord_q, ord_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic [1:0]       code_q, code_d;
    logic             ovf_q, ovf_d;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Free-running sample divider; a tick is the cycle it sits at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == '0);

    // Debounce: a level flips only after DB_SAMPLES consecutive differing samples.
    always_comb begin
        lvl_d = lvl_q;
        dbc_d = dbc_q;
        if (tick) begin
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (dbc_q[i] == 4'(DB_SAMPLES - 1)) begin
                        lvl_d[i] = ~lvl_q[i];
                        dbc_d[i] = '0;
                    end else begin
                        dbc_d[i] = dbc_q[i] + 1'b1;
                    end
                end else begin
                    dbc_d[i] = '0;
                end
            end
        end
    end

    // Debounced levels, their one-cycle delayed copy and the sample counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q     <= '0;
            lvl_dly_q <= '0;
            dbc_q     <= '0;
        end else begin
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            dbc_q     <= dbc_d;
        end
    end

    // Rising-edge events; releases are deliberately ignored.
    assign evt = lvl_q & ~lvl_dly_q;

    // Priority pick: ENTER wins, then UP > DOWN > LEFT > RIGHT; losers are dropped.
    always_comb begin
        is_enter = evt[0];
        dir_vld  = |evt[4:1];
        if (evt[4]) begin
            dir_code = 2'd0;
        end else if (evt[3]) begin
            dir_code = 2'd1;
        end else if (evt[2]) begin
            dir_code = 2'd2;
        end else begin
            dir_code = 2'd3;
        end
    end

    // Order FSM next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        ord_d   = ord_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        code_d  = code_q;
        ovf_d   = 1'b0;
        case (state_q)
            StEntry: begin
                if (is_enter) begin
                    if (cnt_q != '0) begin
                        state_d = StDone;
                    end
                end else if (dir_vld) begin
                    for (int i = 0; i < int'(MAX_MOVES); i++) begin
                        if (cnt_q == CntW'(i)) begin
                            ord_d[2*i +: 2] = dir_code;
                        end
                    end
                    cnt_d  = cnt_q + 1'b1;
                    vld_d  = 1'b1;
                    code_d = dir_code;
                    if (cnt_q == CntW'(MAX_MOVES - 1)) begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (is_enter) begin
                    state_d = StDone;
                end else if (dir_vld) begin
                    ovf_d = 1'b1;
                end
            end
            StDone: begin
                if (is_enter) begin
                    ord_d   = '0;
                    cnt_d   = '0;
                    state_d = StEntry;
                end
            end
            default: begin
                state_d = StEntry;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEntry;
            ord_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ord_q   <= ord_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ord       = ord_q;
    assign cnt       = {{(OrdW - CntW){1'b0}}, cnt_q};
    assign comp      = (state_q == StDone);
    assign move_vld  = vld_q;
    assign move_code = code_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_order_entry.sv
// tb_order_entry: directed scenarios plus random button presses, checked
// against a queue-based model of the move order.
module tb_order_entry;

    localparam int unsigned MaxMoves = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btn = '0;
    logic [27:0] ord;
    logic [27:0] cnt;
    logic        comp;
    logic        move_vld;
    logic [1:0]  move_code;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor results.
    int         vld_seen = 0;
    int         ovf_seen = 0;
    logic [1:0] last_code = '0;

    // Reference model: list of stored codes plus committed flag.
    int q[$];
    bit m_done = 1'b0;

    order_entry #(
        .DIV_W      (2),
        .DB_SAMPLES (3),
        .MAX_MOVES  (MaxMoves)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .ord       (ord),
        .cnt       (cnt),
        .comp      (comp),
        .move_vld  (move_vld),
        .move_code (move_code),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (move_vld) begin
                vld_seen  <= vld_seen + 1;
                last_code <= move_code;
            end
            if (ovf) begin
                ovf_seen <= ovf_seen + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_ord();
        logic [31:0] w = '0;
        foreach (q[i]) w = w | (32'(q[i]) << (2 * i));
        return w;
    endfunction

    // Press the buttons in mask (optionally bouncing first), release, then compare.
    task automatic do_press(input logic [4:0] mask, input bit bouncy, input string tag);
        int v0 = vld_seen;
        int o0 = ovf_seen;
        int ev = 0;
        int eo = 0;
        int code = 0;
        if (mask[0]) begin
            if (m_done) begin
                q.delete();
                m_done = 1'b0;
            end else if (q.size() > 0) begin
                m_done = 1'b1;
            end
        end else begin
            code = mask[4] ? 0 : mask[3] ? 1 : mask[2] ? 2 : 3;
            if (!m_done) begin
                if (q.size() < int'(MaxMoves)) begin
                    q.push_back(code);
                    ev = 1;
                end else begin
                    eo = 1;
                end
            end
        end
        @(negedge clk);
        if (bouncy) begin
            for (int k = 0; k < 15; k++) begin
                btn = (k % 2 == 0) ? mask : 5'b0;
                repeat (2) @(negedge clk);
            end
        end
        btn = mask;
        repeat (20 + $urandom_range(0, 8)) @(negedge clk);
        btn = '0;
        repeat (20 + $urandom_range(0, 8)) @(negedge clk);
        check({tag, ".ord"}, 32'(ord), model_ord());
        check({tag, ".cnt"}, 32'(cnt), 32'(q.size()));
        check({tag, ".comp"}, 32'(comp), 32'(m_done));
        check({tag, ".vld"}, 32'(vld_seen - v0), 32'(ev));
        check({tag, ".ovf"}, 32'(ovf_seen - o0), 32'(eo));
        if (ev != 0) check({tag, ".code"}, 32'(last_code), 32'(code));
    endtask

    localparam logic [4:0] BUp = 5'b10000, BDn = 5'b01000, BLf = 5'b00100;
    localparam logic [4:0] BRt = 5'b00010, BEn = 5'b00001;

    initial begin
        logic [4:0] dirs[4];
        int v0;
        dirs[0] = BUp; dirs[1] = BDn; dirs[2] = BLf; dirs[3] = BRt;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst.ord", 32'(ord), 32'd0);
        check("rst.cnt", 32'(cnt), 32'd0);
        check("rst.comp", 32'(comp), 32'd0);
        check("rst.vld", 32'(move_vld), 32'd0);
        check("rst.code", 32'(move_code), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Four clean presses, commit, clear.
        do_press(BUp, 1'b0, "p_up");
        do_press(BRt, 1'b0, "p_rt");
        do_press(BLf, 1'b0, "p_lf");
        do_press(BDn, 1'b0, "p_dn");
        check("four.ord", 32'(ord), 32'h6C);
        do_press(BEn, 1'b0, "commit4");
        do_press(BEn, 1'b0, "clear4");

        // ENTER on an empty order does nothing; bouncy RIGHT gives one move.
        do_press(BEn, 1'b0, "enter_empty");
        do_press(BRt, 1'b1, "bouncy_rt");
        do_press(BEn, 1'b0, "commit_b");
        do_press(BEn, 1'b0, "clear_b");

        // Fill the order with alternating UP/RIGHT, overflow, commit.
        for (int i = 0; i < 15; i++) do_press((i % 2 == 0) ? BUp : BRt, 1'b0, "fill");
        check("full.ord", 32'(ord), 32'h0CCC_CCCC);
        do_press(BEn, 1'b0, "commit_full");
        do_press(BLf, 1'b0, "done_left");
        do_press(BEn, 1'b0, "clear_full");

        // Simultaneous UP and ENTER with three moves stored.
        do_press(BDn, 1'b0, "s1");
        do_press(BLf, 1'b0, "s2");
        do_press(BUp, 1'b0, "s3");
        do_press(BUp | BEn, 1'b0, "simul");
        do_press(BEn, 1'b0, "clear_s");

        // Five moves, then an asynchronous reset with DOWN held.
        for (int i = 0; i < 5; i++) do_press(dirs[i % 4], 1'b0, "pre_rst");
        @(negedge clk);
        btn = BDn;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.ord", 32'(ord), 32'd0);
        check("arst.cnt", 32'(cnt), 32'd0);
        check("arst.comp", 32'(comp), 32'd0);
        check("arst.vld", 32'(move_vld), 32'd0);
        check("arst.code", 32'(move_code), 32'd0);
        check("arst.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        q.delete();
        m_done = 1'b0;
        v0 = vld_seen;
        repeat (30) @(negedge clk);
        q.push_back(1);
        check("held.cnt", 32'(cnt), 32'd1);
        check("held.ord", 32'(ord), model_ord());
        check("held.vld", 32'(vld_seen - v0), 32'd1);
        check("held.code", 32'(last_code), 32'd1);
        btn = '0;
        repeat (25) @(negedge clk);

        // Random presses, ENTER about one time in six.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) do_press(BEn, 1'b0, "rnd_en");
            else do_press(dirs[$urandom_range(0, 3)], 1'b0, "rnd_dir");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
